alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_seq_if.sv | 39 +++
 rtl/alu_shift_iter.sv | 37 +++
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes (also used by the
// ALU controller), the FSM state type and a shift-code helper.
package alu_pkg;

  localparam logic [3:0] CtrlAnd  = 4'd0;
  localparam logic [3:0] CtrlOr   = 4'd1;
  localparam logic [3:0] CtrlAdd  = 4'd2;
  localparam logic [3:0] CtrlSub  = 4'd3;
  localparam logic [3:0] CtrlSlt  = 4'd4;
  localparam logic [3:0] CtrlSltu = 4'd5;
  localparam logic [3:0] CtrlBne  = 4'd6;
  localparam logic [3:0] CtrlSll  = 4'd7;
  localparam logic [3:0] CtrlSllv = 4'd8;
  localparam logic [3:0] CtrlLui  = 4'd9;
  localparam logic [3:0] CtrlOri  = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_e;

  function automatic logic is_shift(logic [3:0] code);
    return (code == CtrlSll) || (code == CtrlSllv);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU. overflow_o exists only when
// ALU_OVF_EN is defined.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [4:0]       shamt_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             illegal_o;
`ifdef ALU_OVF_EN
  logic             overflow_o;
`endif

  // Requester / result consumer side
  modport master (
    output valid_i, ctrl_i, src1_i, src2_i, shamt_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, illegal_o
`ifdef ALU_OVF_EN
    , input overflow_o
`endif
  );

  // ALU side
  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i, shamt_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, illegal_o
`ifdef ALU_OVF_EN
    , output overflow_o
`endif
  );

endinterface

// File: rtl/alu_shift_iter.sv
// Bit-serial left shifter. The first bit is shifted during load so that an
// n-bit shift needs only n-1 further steps.
module alu_shift_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic [4:0]       amt_i,
  output logic [WIDTH-1:0] next_o,
  output logic             last_o
);

  logic [WIDTH-1:0] work_q;
  logic [4:0]       cnt_q;

  // Working register and remaining-count update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      work_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      work_q <= val_i << 1;
      cnt_q  <= amt_i;
    end else if (step_i) begin
      work_q <= work_q << 1;
      cnt_q  <= cnt_q - 5'd1;
    end
  end

  // Value after the current step; last when this step brings the count to 1
  assign next_o = work_q << 1;
  assign last_o = (cnt_q <= 5'd2);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one operation per handshake, single-cycle logic ops,
// bit-serial SLL/SLLV, result held until accepted downstream.
// Define ALU_OVF_EN to add the registered signed-overflow output.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  alu_seq_if.slave   alu_bus
);

  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic             capture;

  logic [WIDTH-1:0] src1, src2, sum, diff, alu_res;
  logic             alu_ill;
  logic [4:0]       shift_amt;

  logic             sh_load, sh_step, sh_last;
  logic [WIDTH-1:0] sh_next;

`ifdef ALU_OVF_EN
  logic             ovf_q, ovf_d, alu_ovf;
`endif

  assign src1      = alu_bus.src1_i;
  assign src2      = alu_bus.src2_i;
  assign sum       = src1 + src2;
  assign diff      = src1 - src2;
  assign shift_amt = (alu_bus.ctrl_i == CtrlSllv) ? src1[4:0] : alu_bus.shamt_i;

  // Single-cycle operation results
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef ALU_OVF_EN
    alu_ovf = 1'b0;
`endif
    case (alu_bus.ctrl_i)
      CtrlAnd:  alu_res = src1 & src2;
      CtrlOr:   alu_res = src1 | src2;
      CtrlAdd: begin
        alu_res = sum;
`ifdef ALU_OVF_EN
        alu_ovf = (src1[Msb] == src2[Msb]) && (sum[Msb] != src1[Msb]);
`endif
      end
      CtrlSub, CtrlBne: begin
        alu_res = diff;
`ifdef ALU_OVF_EN
        alu_ovf = (src1[Msb] != src2[Msb]) && (diff[Msb] != src1[Msb]);
`endif
      end
      CtrlSlt:  alu_res[0] = $signed(src1) < $signed(src2);
      CtrlSltu: alu_res[0] = src1 < src2;
      CtrlSll, CtrlSllv: alu_res = '0;  // handled by the shifter
      CtrlLui:  alu_res = WIDTH'({src2[15:0], 16'h0000});
      CtrlOri:  alu_res = src1 | WIDTH'(src2[15:0]);
      default:  alu_ill = 1'b1;
    endcase
  end

  // Next state, shifter control and result capture
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    zero_d    = zero_q;
    capture   = 1'b0;
    sh_load   = 1'b0;
    sh_step   = 1'b0;
`ifdef ALU_OVF_EN
    ovf_d     = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (alu_bus.valid_i) begin
          illegal_d = 1'b0;
`ifdef ALU_OVF_EN
          ovf_d     = 1'b0;
`endif
          if (is_shift(alu_bus.ctrl_i)) begin
            if (shift_amt == 5'd0) begin
              result_d = src2;
              capture  = 1'b1;
              state_d  = StDone;
            end else if (shift_amt == 5'd1) begin
              result_d = src2 << 1;
              capture  = 1'b1;
              state_d  = StDone;
            end else begin
              sh_load  = 1'b1;
              state_d  = StShift;
            end
          end else begin
            result_d  = alu_res;
            illegal_d = alu_ill;
`ifdef ALU_OVF_EN
            ovf_d     = alu_ovf;
`endif
            capture   = 1'b1;
            state_d   = StDone;
          end
        end
      end
      StShift: begin
        sh_step = 1'b1;
        if (sh_last) begin
          result_d = sh_next;
          capture  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (alu_bus.ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (capture) zero_d = (result_d == '0);
  end

  // State and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  alu_shift_iter #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (sh_load),
    .step_i (sh_step),
    .val_i  (src2),
    .amt_i  (shift_amt),
    .next_o (sh_next),
    .last_o (sh_last)
  );

  // ready_o is held low while reset is asserted
  assign alu_bus.ready_o   = (state_q == StIdle) && !rst_i;
  assign alu_bus.valid_o   = (state_q == StDone);
  assign alu_bus.result_o  = result_q;
  assign alu_bus.zero_o    = zero_q;
  assign alu_bus.illegal_o = illegal_q;
`ifdef ALU_OVF_EN
  assign alu_bus.overflow_o = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed, table-driven bench for alu_seq plus hand-written sequences for
// hold, early ready, and reset during a shift.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  alu_seq_if #(.WIDTH(32)) bus();

  alu_seq #(
    .WIDTH (32)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .alu_bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        ill;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic void add(string name, logic [3:0] ctrl, logic [31:0] s1, logic [31:0] s2,
                              logic [4:0] sh, logic [31:0] res, logic z, logic ill, logic ovf,
                              int lat);
    vec_t v;
    v.name = name; v.ctrl = ctrl; v.s1 = s1; v.s2 = s2; v.sh = sh;
    v.res = res; v.z = z; v.ill = ill; v.ovf = ovf; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, measure latency, check outputs, then retire it
  task automatic run(input vec_t v, input bit early);
    int lat;
    int wt;
    bus.ctrl_i  = v.ctrl;
    bus.src1_i  = v.s1;
    bus.src2_i  = v.s2;
    bus.shamt_i = v.sh;
    bus.valid_i = 1'b1;
    bus.ready_i = early;
    wt = 0;
    while (!bus.ready_o && wt < 8) begin
      tick();
      wt++;
    end
    chk({v.name, " ready_o"}, 32'(bus.ready_o), 32'd1);
    tick();
    bus.valid_i = 1'b0;
    bus.ctrl_i  = CtrlAnd;
    lat = 1;
    while (!bus.valid_o && lat < 40) begin
      tick();
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.lat));
    chk({v.name, " result"}, bus.result_o, v.res);
    chk({v.name, " zero"}, 32'(bus.zero_o), 32'(v.z));
    chk({v.name, " illegal"}, 32'(bus.illegal_o), 32'(v.ill));
`ifdef ALU_OVF_EN
    chk({v.name, " overflow"}, 32'(bus.overflow_o), 32'(v.ovf));
`endif
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk({v.name, " valid_o drop"}, 32'(bus.valid_o), 32'd0);
    chk({v.name, " ready_o rise"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    vec_t v;
    bit   seen;

    //   name         ctrl      src1          src2          sh     result        z  ill ovf lat
    add("add_ovf",    CtrlAdd,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 0, 0, 1, 1);
    add("sub_eq",     CtrlSub,  32'd5,        32'd5,        5'd0,  32'h0,        1, 0, 0, 1);
    add("bne_eq",     CtrlBne,  32'd3,        32'd3,        5'd0,  32'h0,        1, 0, 0, 1);
    add("slt_neg",    CtrlSlt,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h1,        0, 0, 0, 1);
    add("sltu_big",   CtrlSltu, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h0,        1, 0, 0, 1);
    add("sll_31",     CtrlSll,  32'h0,        32'h00000001, 5'd31, 32'h80000000, 0, 0, 0, 31);
    add("sllv_25",    CtrlSllv, 32'h00000025, 32'h00000001, 5'd0,  32'h00000020, 0, 0, 0, 5);
    add("sll_0",      CtrlSll,  32'h0,        32'h00001234, 5'd0,  32'h00001234, 0, 0, 0, 1);
    add("sll_1",      CtrlSll,  32'h0,        32'h00000003, 5'd1,  32'h00000006, 0, 0, 0, 1);
    add("sll_2",      CtrlSll,  32'h0,        32'h00000003, 5'd2,  32'h0000000C, 0, 0, 0, 2);
    add("sllv_hi",    CtrlSllv, 32'hFFFFFFE3, 32'h00000001, 5'd0,  32'h00000008, 0, 0, 0, 3);
    add("lui",        CtrlLui,  32'h0,        32'h0000ABCD, 5'd0,  32'hABCD0000, 0, 0, 0, 1);
    add("ori",        CtrlOri,  32'hF0000000, 32'hFFFF1234, 5'd0,  32'hF0001234, 0, 0, 0, 1);
    add("illegal_c",  4'hC,     32'h12345678, 32'h9ABCDEF0, 5'd0,  32'h0,        1, 1, 0, 1);
    add("or",         CtrlOr,   32'h00000F00, 32'h000000F0, 5'd0,  32'h00000FF0, 0, 0, 0, 1);
    add("sub_ovf",    CtrlSub,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 0, 0, 1, 1);
    add("add_wrap",   CtrlAdd,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h0,        1, 0, 0, 1);
    add("bne_ne",     CtrlBne,  32'h00000001, 32'h00000002, 5'd0,  32'hFFFFFFFF, 0, 0, 0, 1);

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.ctrl_i  = CtrlAnd;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.shamt_i = '0;

    // Reset
    rst = 1'b1;
    tick();
    chk("reset ready_o low", 32'(bus.ready_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset ready_o", 32'(bus.ready_o), 32'd1);
    chk("reset valid_o", 32'(bus.valid_o), 32'd0);
    chk("reset result", bus.result_o, 32'h0);
    chk("reset zero", 32'(bus.zero_o), 32'd0);
    chk("reset illegal", 32'(bus.illegal_o), 32'd0);
`ifdef ALU_OVF_EN
    chk("reset overflow", 32'(bus.overflow_o), 32'd0);
`endif

    foreach (vecs[i]) run(vecs[i], 1'b0);

    // Early ready_i during a shift must not shorten it
    v.name = "sll_4_early"; v.ctrl = CtrlSll; v.s1 = '0; v.s2 = 32'h5; v.sh = 5'd4;
    v.res = 32'h50; v.z = 1'b0; v.ill = 1'b0; v.ovf = 1'b0; v.lat = 4;
    run(v, 1'b1);

    // Illegal op held in DONE for 5 cycles while a new request is offered
    bus.ctrl_i  = 4'hC;
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b0;
    tick();
    bus.ctrl_i = CtrlAnd;
    bus.src1_i = 32'hFFFFFFFF;
    bus.src2_i = 32'hFFFFFFFF;
    chk("hold valid_o", 32'(bus.valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d valid_o", i), 32'(bus.valid_o), 32'd1);
      chk($sformatf("hold%0d ready_o", i), 32'(bus.ready_o), 32'd0);
      chk($sformatf("hold%0d result", i), bus.result_o, 32'h0);
      chk($sformatf("hold%0d illegal", i), 32'(bus.illegal_o), 32'd1);
      chk($sformatf("hold%0d zero", i), 32'(bus.zero_o), 32'd1);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    chk("hold release valid_o", 32'(bus.valid_o), 32'd0);
    chk("hold release ready_o", 32'(bus.ready_o), 32'd1);
    tick();
    chk("ignored request valid_o", 32'(bus.valid_o), 32'd0);
    chk("ignored request ready_o", 32'(bus.ready_o), 32'd1);

    // Reset in cycle 3 of a 20-bit shift
    bus.ctrl_i  = CtrlSll;
    bus.src2_i  = 32'h1;
    bus.shamt_i = 5'd20;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    chk("shift busy ready_o", 32'(bus.ready_o), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("abort ready_o in reset", 32'(bus.ready_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort valid_o", 32'(bus.valid_o), 32'd0);
    chk("abort ready_o", 32'(bus.ready_o), 32'd1);
    chk("abort result", bus.result_o, 32'h0);
    chk("abort zero", 32'(bus.zero_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.valid_o) seen = 1'b1;
    end
    chk("abort result lost", 32'(seen), 32'd0);

    v.name = "and_after_abort"; v.ctrl = CtrlAnd; v.s1 = 32'hF0F0; v.s2 = 32'hFF00; v.sh = 5'd0;
    v.res = 32'hF000; v.z = 1'b0; v.ill = 1'b0; v.ovf = 1'b0; v.lat = 1;
    run(v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
